// File: rtl/burst_rr_scheduler.sv
// Burst-granular round-robin scheduler: one requester owns the sink for a whole burst.
// Optional stall timeout with error pulse: define BURST_RR_SCHEDULER_TIMEOUT_EN.
module burst_rr_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int DW      = 8,
    parameter int LENW    = 4,
    parameter int TIMEOUT = 15,
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    asrst,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ*LENW-1:0] req_len,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic                    m_vld,
    output logic [DW-1:0]           m_data,
    output logic                    m_last,
    input  logic                    m_rdy,
    output logic [GW-1:0]           grant_id,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q;
    logic [LENW-1:0] cnt_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_q;
    logic [GW-1:0]   pick_s;
    logic            found_s;
    logic            in_burst_s;
    logic            xfer_s;

`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q;
    logic          err_q;
`endif

    // Round-robin search starting just after the last winner
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found_s && req_vld[idx]) begin
                found_s = 1'b1;
                pick_s  = GW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Reset forces the sink-side and requester-side handshakes quiet immediately
    assign in_burst_s = (state_q == BURST) && !asrst;

    // Zero-latency steering of the granted requester onto the sink
    always_comb begin
        m_vld   = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        req_rdy = '0;
        if (in_burst_s) begin
            m_vld            = req_vld[grant_q];
            m_data           = req_data[grant_q*DW +: DW];
            m_last           = req_vld[grant_q] && (cnt_q == '0);
            req_rdy[grant_q] = m_rdy;
        end else begin
            m_vld = 1'b0;
        end
    end

    assign xfer_s   = m_vld && m_rdy;
    assign busy     = in_burst_s;
    assign grant_id = grant_q;

`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
    assign err = err_q && !asrst;
`else
    assign err = 1'b0;
`endif

    // Arbitration / burst FSM
    always_ff @(posedge clk) begin
        if (asrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
            stall_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
                    stall_q <= '0;
`endif
                    if (en && found_s) begin
                        grant_q <= pick_s;
                        cnt_q   <= req_len[pick_s*LENW +: LENW];
                        state_q <= BURST;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BURST: begin
                    if (xfer_s) begin
`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
                        stall_q <= '0;
`endif
                        if (cnt_q == '0) begin
                            last_q  <= grant_q;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
                    // Any non-transfer cycle in BURST is a stall; the TIMEOUT-th one aborts
                    else if (stall_q == SW'(TIMEOUT - 1)) begin
                        stall_q <= '0;
                        err_q   <= 1'b1;
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`else
                    else begin
                        state_q <= BURST;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Directed scoreboard bench for burst_rr_scheduler (NUM_REQ=3, DW=8, LENW=4, TIMEOUT=15).
module tb_burst_rr_scheduler;

    localparam int NUM_REQ = 3;
    localparam int DW      = 8;
    localparam int LENW    = 4;
    localparam int TIMEOUT = 15;
    localparam int GW      = 2;

    logic                    clk = 1'b0;
    logic                    asrst;
    logic                    en;
    logic [NUM_REQ-1:0]      req_vld;
    logic [NUM_REQ*LENW-1:0] req_len;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_rdy;
    logic                    m_vld;
    logic [DW-1:0]           m_data;
    logic                    m_last;
    logic                    m_rdy;
    logic [GW-1:0]           grant_id;
    logic                    busy;
    logic                    err;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [GW-1:0] gid;
    } beat_t;

    beat_t         sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] base [NUM_REQ];
    int            bidx [NUM_REQ];
    int            rem  [NUM_REQ];
    int            used;

    burst_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW),
        .LENW    (LENW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .asrst    (asrst),
        .en       (en),
        .req_vld  (req_vld),
        .req_len  (req_len),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .m_vld    (m_vld),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_rdy    (m_rdy),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DW +: DW] = base[i] + DW'(bidx[i]);
        end
    endtask

    task automatic launch(input int i, input logic [LENW-1:0] len, input logic [DW-1:0] b, input int n);
        req_len[i*LENW +: LENW] = len;
        base[i]    = b;
        bidx[i]    = 0;
        rem[i]     = n;
        req_vld[i] = 1'b1;
        refresh();
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l, input logic [GW-1:0] g);
        beat_t e;
        e.data = d;
        e.last = l;
        e.gid  = g;
        sb.push_back(e);
    endtask

    // One clock: sample before the rising edge, retire accepted beats after it
    task automatic cycle();
        logic [NUM_REQ-1:0] adv;
        beat_t              e;
        adv = '0;
        #1;
        if (m_vld && m_rdy) begin
            chk("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_data", 32'(m_data), 32'(e.data));
                chk("beat_last", 32'(m_last), 32'(e.last));
                chk("beat_gid", 32'(grant_id), 32'(e.gid));
                chk("beat_rdy", 32'(req_rdy[e.gid]), 32'd1);
            end
            adv = req_rdy & req_vld;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (adv[i]) begin
                bidx[i]++;
                rem[i]--;
                if (rem[i] <= 0) req_vld[i] = 1'b0;
            end
        end
        refresh();
        @(negedge clk);
    endtask

    task automatic drain(input int max, output int n);
        n = 0;
        while (sb.size() != 0 && n < max) begin
            cycle();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        asrst   = 1'b1;
        en      = 1'b0;
        m_rdy   = 1'b0;
        req_vld = '0;
        req_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            base[i] = 8'h00;
            bidx[i] = 0;
            rem[i]  = 0;
        end
        refresh();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_vld", 32'(m_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        asrst = 1'b0;

        // All three request single-beat bursts; requester 0 asks twice
        en    = 1'b1;
        m_rdy = 1'b1;
        launch(0, 4'd0, 8'h10, 2);
        launch(1, 4'd0, 8'h20, 1);
        launch(2, 4'd0, 8'h30, 1);
        push(8'h10, 1'b1, 2'd0);
        push(8'h20, 1'b1, 2'd1);
        push(8'h30, 1'b1, 2'd2);
        push(8'h11, 1'b1, 2'd0);
        drain(20, used);
        chk("t1_cycles", 32'(used), 32'd8);

        // Four-beat burst with a toggling sink ready
        launch(1, 4'd3, 8'hA0, 4);
        push(8'hA0, 1'b0, 2'd1);
        push(8'hA1, 1'b0, 2'd1);
        push(8'hA2, 1'b0, 2'd1);
        push(8'hA3, 1'b1, 2'd1);
        for (int k = 0; k < 30 && sb.size() != 0; k++) begin
            m_rdy = (k % 2 == 0);
            #1;
            if (k > 0) chk("t2_busy", 32'(busy), 32'd1);
            cycle();
        end
        chk("t2_empty", 32'(sb.size()), 32'd0);
        m_rdy = 1'b1;

        // Requester 0 arrives mid-burst and must wait for all 8 beats of requester 2
        launch(2, 4'd7, 8'hC0, 8);
        for (int j = 0; j < 8; j++) push(8'hC0 + 8'(j), (j == 7), 2'd2);
        cycle();
        cycle();
        cycle();
        launch(0, 4'd0, 8'h30, 1);
        push(8'h30, 1'b1, 2'd0);
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            #1;
            if (sb.size() > 1) chk("t3_no_rdy0", 32'(req_rdy[0]), 32'd0);
            cycle();
        end
        chk("t3_empty", 32'(sb.size()), 32'd0);

        // Arbitration gated by en
        en = 1'b0;
        launch(1, 4'd0, 8'h50, 1);
        push(8'h50, 1'b1, 2'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_busy_off", 32'(busy), 32'd0);
            chk("t4_m_vld_off", 32'(m_vld), 32'd0);
            cycle();
        end
        en = 1'b1;
        cycle();
        #1;
        chk("t4_grant", 32'(grant_id), 32'd1);
        chk("t4_busy_on", 32'(busy), 32'd1);
        drain(4, used);

        // Reset in the middle of a burst from requester 2
        launch(2, 4'd5, 8'hE0, 6);
        push(8'hE0, 1'b0, 2'd2);
        cycle();
        cycle();
        asrst = 1'b1;
        #1;
        chk("t5_rst_m_vld", 32'(m_vld), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("t5_rst_m_last", 32'(m_last), 32'd0);
        cycle();
        asrst   = 1'b0;
        req_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
        #1;
        chk("t5_grant_rst", 32'(grant_id), 32'd0);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_m_vld_idle", 32'(m_vld), 32'd0);
        chk("t5_empty", 32'(sb.size()), 32'd0);
        launch(0, 4'd0, 8'h80, 1);
        launch(1, 4'd0, 8'h90, 1);
        launch(2, 4'd0, 8'hB0, 1);
        push(8'h80, 1'b1, 2'd0);
        push(8'h90, 1'b1, 2'd1);
        push(8'hB0, 1'b1, 2'd2);
        drain(20, used);

        // Sink stalls for TIMEOUT cycles in the middle of a two-beat burst
        launch(1, 4'd1, 8'h60, 2);
        launch(2, 4'd0, 8'h70, 1);
        push(8'h60, 1'b0, 2'd1);
        cycle();
        cycle();
        m_rdy = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            #1;
            chk("t6_err_quiet", 32'(err), 32'd0);
            chk("t6_busy_stall", 32'(busy), 32'd1);
            cycle();
        end
        #1;
`ifdef BURST_RR_SCHEDULER_TIMEOUT_EN
        chk("t6_err_pulse", 32'(err), 32'd1);
        chk("t6_busy_abort", 32'(busy), 32'd0);
        req_vld[1] = 1'b0;
        rem[1]     = 0;
        push(8'h70, 1'b1, 2'd2);
`else
        chk("t6_err_none", 32'(err), 32'd0);
        chk("t6_busy_hold", 32'(busy), 32'd1);
        push(8'h61, 1'b1, 2'd1);
        push(8'h70, 1'b1, 2'd2);
`endif
        m_rdy = 1'b1;
        drain(20, used);
        #1;
        chk("t6_err_after", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/burst_rr_scheduler.md
Name: burst_rr_scheduler

Overview:
- Shares one downstream sink port between NUM_REQ requesters on a per-burst basis.
- Round-robin arbitration picks one requester, then holds the grant for the whole burst.
- The winner's beats pass to the sink through a valid/ready handshake.
- Sits in front of any shared datapath resource that must not interleave beats from different sources.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DW, 8, data width per beat.
- LENW, 4, width of burst-length field; a burst carries len+1 beats (1..2^LENW).
- TIMEOUT, 15, stall-cycle limit used only by the optional feature.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- asrst  in  1  reset; synchronous, active-high.
- en  in  1  arbitration enable; new bursts start only when high.
- req_vld  in  NUM_REQ  per-requester beat valid; also acts as burst request when idle.
- req_len  in  NUM_REQ*LENW  per-requester beats-1; slice i = bits [i*LENW +: LENW].
- req_data  in  NUM_REQ*DW  per-requester beat data; slice i = bits [i*DW +: DW].
- req_rdy  out  NUM_REQ  per-requester beat accept.
- m_vld  out  1  sink beat valid.
- m_data  out  DW  sink beat data.
- m_last  out  1  marks final beat of burst.
- m_rdy  in  1  sink ready.
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester.
- busy  out  1  high while in BURST.
- err  out  1  timeout pulse; driven 0 when the optional feature is compiled out.

Behaviour:
- Reset (asrst=1 at clock edge):
  - state=IDLE, beat counter=0, grant_id=0, err=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has highest priority first.
  - An active burst is abandoned with no further beats.
- While in IDLE or held in reset, all outputs are 0: m_vld, m_last, req_rdy, busy.
- FSM states: IDLE, BURST.
- IDLE:
  - If en=1 and any req_vld: choose first i with req_vld[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - Register grant_id=i and beat counter=req_len[i]; next state BURST.
  - Grant latency is 1 cycle: no beat transfers in the arbitration cycle.
  - req_len is sampled only at this edge.
- BURST:
  - m_vld = req_vld[grant_id]; m_data = req_data slice grant_id.
  - req_rdy[grant_id] = m_rdy; all other req_rdy bits are 0. Combinational, zero latency.
  - m_last = m_vld & (counter==0). busy=1.
  - A beat transfers when req_vld[grant_id] & m_rdy; the counter then decrements.
  - Transfer with counter==0: last=grant_id; next state IDLE.
  - At least one IDLE cycle separates bursts.
- Requester drops req_vld mid-burst: m_vld=0, grant held, counter unchanged; wait indefinitely (unless timeout enabled).
- en deasserted in BURST: burst runs to completion. en low in IDLE: no new grant; requests stay pending.
- Non-granted requesters see req_rdy=0 and must hold their request.
- Single requester repeatedly requesting: re-granted each time; one idle cycle between bursts.
- len=0: one-beat burst; m_last high on its only beat.
- Pointer wrap: last=NUM_REQ-1 searches from 0.
- Simultaneous asrst and final transfer: reset wins.

Optional Feature:
- Macro BURST_RR_SCHEDULER_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive BURST cycles with m_vld=1 & m_rdy=0, or with req_vld[grant_id]=0.
  - It clears on any transfer.
  - On reaching TIMEOUT: abort the burst, pulse err=1 for one cycle, set last=grant_id, return to IDLE.
  - Remaining beats are dropped, with no m_last.
- Undefined: no stall counter; err tied 0; bursts wait indefinitely.

Test Plan:
- Reset, then req_vld=3'b111, all len=0, m_rdy=1, en=1 -> grant_id sequence 0,1,2,0; one beat each with m_last=1; IDLE cycle between bursts.
- req_vld[1]=1, len=3, data 0xA0..0xA3, m_rdy toggling 1,0,1,0... -> exactly 4 beats A0..A3 in order; m_last only on A3; busy high throughout; grant_id=1.
- Burst from req 2 in progress (len=7); req 0 asserts mid-burst -> req 0 gets no req_rdy until req 2's 8th beat; next grant goes to req 0.
- en=0 with req_vld=3'b010 -> stays IDLE, busy=0; set en=1 -> grant_id=1 one cycle later.
- asrst pulsed on beat 2 of a len=5 burst -> next cycle IDLE, outputs 0, last=2; with req_vld=3'b111, requester 0 is granted first.
- With BURST_RR_SCHEDULER_TIMEOUT_EN and TIMEOUT=15: hold m_rdy=0 for 15 cycles during a burst -> err pulses once; state IDLE; next grant goes to the following requester. Without the macro: no err; burst resumes when m_rdy=1.
